layer_target_reducer: RTL and testbench

// - Backward-path partner of the learning neuron. Each of M downstream neurons emits an

---
 rtl/layer_target_reducer.sv | 149 ++++++++++++++
 tb/tb_layer_target_reducer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/layer_target_reducer.sv
// Collects M downstream expected_in vectors and emits their per-lane rounded mean.
// Optional synchronous flush input enabled by defining TARGET_REDUCE_FLUSH_EN.

package layer_target_reducer_pkg;
   typedef logic [7:0] zero2one_t;
endpackage

module layer_target_reducer
   import layer_target_reducer_pkg::*;
#(
   parameter int unsigned N = 16,
   parameter int unsigned M = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  zero2one_t [N-1:0]     in_target,
   output logic                  out_valid,
   input  logic                  out_ready,
   output zero2one_t [N-1:0]     out_target
`ifdef TARGET_REDUCE_FLUSH_EN
   ,
   input  logic                  flush
`endif
);

   localparam int unsigned W      = $bits(zero2one_t);
   localparam int unsigned CNT_W  = $clog2(M + 1);
   localparam int unsigned ACC_W  = W + CNT_W;
   localparam int unsigned LANE_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCUM  = 2'd1;
   localparam logic [1:0] DIVIDE = 2'd2;
   localparam logic [1:0] OUTPUT = 2'd3;

   logic [1:0]                  state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [N-1:0][ACC_W-1:0]     acc_q, acc_d;
   logic [LANE_W-1:0]           lane_q, lane_d;
   logic                        div_done_q, div_done_d;
   zero2one_t [N-1:0]           out_target_q, out_target_d;
   logic                        out_valid_q, out_valid_d;

   logic                        flush_c;
   logic                        in_ready_c;
   logic                        accept_c;
   logic [ACC_W:0]              div_sum_c;
   logic [ACC_W:0]              div_res_c;

`ifdef TARGET_REDUCE_FLUSH_EN
   assign flush_c = flush;
`else
   assign flush_c = 1'b0;
`endif

   assign in_ready_c = ((state_q == IDLE) || (state_q == ACCUM)) && !flush_c;
   assign accept_c   = in_valid && in_ready_c;

   // Single shared round-half-up divider, fed by the lane currently being reduced.
   assign div_sum_c = (ACC_W + 1)'(acc_q[lane_q]) + (ACC_W + 1)'(M / 2);
   assign div_res_c = div_sum_c / (ACC_W + 1)'(M);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      lane_d       = lane_q;
      div_done_d   = div_done_q;
      out_target_d = out_target_q;
      out_valid_d  = out_valid_q;

      case (state_q)
         IDLE, ACCUM: begin
            if (flush_c) begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (accept_c) begin
               for (int unsigned j = 0; j < N; j++) begin
                  acc_d[j] = acc_q[j] + ACC_W'(in_target[j]);
               end
               if (cnt_q == CNT_W'(M - 1)) begin
                  cnt_d      = '0;
                  lane_d     = '0;
                  div_done_d = 1'b0;
                  state_d    = DIVIDE;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = ACCUM;
               end
            end
         end
         DIVIDE: begin
            // N lane writes, then one cycle to clear the accumulators.
            if (!div_done_q) begin
               out_target_d[lane_q] = W'(div_res_c);
               if (lane_q == LANE_W'(N - 1)) begin
                  lane_d     = '0;
                  div_done_d = 1'b1;
               end else begin
                  lane_d = lane_q + LANE_W'(1);
               end
            end else begin
               acc_d       = '0;
               div_done_d  = 1'b0;
               out_valid_d = 1'b1;
               state_d     = OUTPUT;
            end
         end
         OUTPUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         acc_q        <= '0;
         lane_q       <= '0;
         div_done_q   <= 1'b0;
         out_target_q <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         lane_q       <= lane_d;
         div_done_q   <= div_done_d;
         out_target_q <= out_target_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign in_ready   = in_ready_c;
   assign out_valid  = out_valid_q;
   assign out_target = out_target_q;

endmodule

// File: tb/tb_layer_target_reducer.sv
// Directed bench for layer_target_reducer with N=2, M=4; flush scenario runs when
// TARGET_REDUCE_FLUSH_EN is defined.

module tb_layer_target_reducer;
   import layer_target_reducer_pkg::*;

   localparam int unsigned N = 2;
   localparam int unsigned M = 4;

   logic              clock;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   zero2one_t [N-1:0] in_target;
   logic              out_valid;
   logic              out_ready;
   zero2one_t [N-1:0] out_target;
`ifdef TARGET_REDUCE_FLUSH_EN
   logic              flush;
`endif

   int checks = 0;
   int errors = 0;
   int lat;

   layer_target_reducer #(.N(N), .M(M)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_target  (in_target),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_target (out_target)
`ifdef TARGET_REDUCE_FLUSH_EN
      ,
      .flush      (flush)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Presents one beat from a falling edge; it is taken on the following rising edge.
   task automatic send_beat(input logic [7:0] a, input logic [7:0] b);
      @(negedge clock);
      in_valid     = 1'b1;
      in_target[0] = a;
      in_target[1] = b;
      check("in_ready_beat", 32'(in_ready), 32'd1);
      @(posedge clock);
   endtask

   // Counts falling edges without out_valid after the last accept; bounded.
   task automatic wait_output(output int cycles);
      cycles = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         in_valid = 1'b0;
         if (out_valid) break;
         cycles++;
      end
      check("out_valid_seen", 32'(out_valid), 32'd1);
   endtask

   task automatic check_out(input string tag, input logic [7:0] e0, input logic [7:0] e1);
      check({tag, "_lane0"}, 32'(out_target[0]), 32'(e0));
      check({tag, "_lane1"}, 32'(out_target[1]), 32'(e1));
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_target = '0;
      out_ready = 1'b1;
`ifdef TARGET_REDUCE_FLUSH_EN
      flush     = 1'b0;
`endif

      // Reset state
      @(negedge clock);
      @(negedge clock);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check_out("rst_out", 8'd0, 8'd0);
      reset = 1'b0;

      // Basic mean with rounding and latency
      send_beat(8'd10, 8'd200);
      send_beat(8'd20, 8'd200);
      send_beat(8'd30, 8'd200);
      send_beat(8'd40, 8'd201);
      wait_output(lat);
      check("latency", 32'(lat), 32'd3);
      check_out("basic", 8'd25, 8'd200);
      @(negedge clock);
      check("valid_one_cycle", 32'(out_valid), 32'd0);
      check("ready_after_out", 32'(in_ready), 32'd1);

      // Full-scale inputs must not overflow
      repeat (4) send_beat(8'd255, 8'd0);
      wait_output(lat);
      check_out("max", 8'd255, 8'd0);

      // Round-half-up on sums 2 and 5
      send_beat(8'd1, 8'd2);
      send_beat(8'd0, 8'd2);
      send_beat(8'd0, 8'd1);
      send_beat(8'd1, 8'd0);
      wait_output(lat);
      check_out("round", 8'd1, 8'd1);

      // Back-pressure in OUTPUT; in_valid pulses must be ignored
      @(negedge clock);
      out_ready = 1'b0;
      repeat (4) send_beat(8'd6, 8'd7);
      wait_output(lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         in_valid     = i[0];
         in_target[0] = 8'd255;
         in_target[1] = 8'd255;
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check_out("hold", 8'd6, 8'd7);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clock);
      check("release_valid", 32'(out_valid), 32'd0);
      check_out("stable_after", 8'd6, 8'd7);
      repeat (4) send_beat(8'd12, 8'd12);
      wait_output(lat);
      check_out("no_leak", 8'd12, 8'd12);

      // Reset mid-accumulation discards partial sums
      send_beat(8'd200, 8'd200);
      send_beat(8'd200, 8'd200);
      @(negedge clock);
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clock);
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_ready", 32'(in_ready), 32'd1);
      check_out("midrst", 8'd0, 8'd0);
      reset = 1'b0;
      repeat (4) send_beat(8'd8, 8'd8);
      wait_output(lat);
      check_out("after_rst", 8'd8, 8'd8);

`ifdef TARGET_REDUCE_FLUSH_EN
      // Flush clears a partial reduction and blocks the concurrent beat
      repeat (3) send_beat(8'd100, 8'd100);
      @(negedge clock);
      flush        = 1'b1;
      in_valid     = 1'b1;
      in_target[0] = 8'd100;
      in_target[1] = 8'd100;
      check("flush_in_ready", 32'(in_ready), 32'd0);
      @(negedge clock);
      flush    = 1'b0;
      in_valid = 1'b0;
      repeat (4) send_beat(8'd4, 8'd4);
      wait_output(lat);
      check_out("flush", 8'd4, 8'd4);
`endif

      @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
